// File: rtl/dport_arb.sv
// dport_arb: two-requester arbiter for a shared data-port memory interface.
//
// Requester 0 is the CPU core data port, requester 1 a secondary master
// (DMA/debug). Requests are granted round-robin; once the memory stalls a
// granted request, the grant is locked until the handshake completes.
// Responses come back in order and are routed to the issuing requester via a
// FIFO of source IDs for accepted-but-unacknowledged requests.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   mN_addr_i/_data_wr_i/_rd_i/_wr_i/_req_tag_i   requester N request
//   mN_accept_o                  requester N request accepted this cycle
//   mN_ack_o/_error_o/_resp_tag_o/_data_rd_o      requester N response
//   mem_addr_o/_data_wr_o/_rd_o/_wr_o/_req_tag_o  muxed request to memory
//   mem_accept_i/_ack_i/_error_i/_resp_tag_i/_data_rd_i  memory handshake
module dport_arb #(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int OUTSTANDING_W     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic [10:0] m0_req_tag_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [10:0] m0_resp_tag_o,
    output logic [31:0] m0_data_rd_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic [10:0] m1_req_tag_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [10:0] m1_resp_tag_o,
    output logic [31:0] m1_data_rd_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [10:0] mem_req_tag_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [10:0] mem_resp_tag_i,
    input  logic [31:0] mem_data_rd_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Count value that means full; DEPTH is a power of two.
    localparam logic [OUTSTANDING_W:0] FULL_CNT = {1'b1, {OUTSTANDING_W{1'b0}}};

    logic [0:0]                   state_q, state_d;
    logic                         owner_q, owner_d;
    logic                         last_q,  last_d;
    logic [OUTSTANDING_DEPTH-1:0] fifo_q;
    logic [OUTSTANDING_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OUTSTANDING_W:0]       count_q, count_d;

    logic act0, act1;
    logic win_idx, win_vld;
    logic fifo_full, fifo_empty;
    logic fire, push, pop, head;
    logic sel_rd;
    logic [3:0] sel_wr;

    assign act0 = m0_rd_i | (|m0_wr_i);
    assign act1 = m1_rd_i | (|m1_wr_i);

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Winner selection: locked owner in HOLD, round-robin tie-break in IDLE.
    // With nobody active the index still selects a requester so the
    // address/data/tag outputs carry a defined pass-through value.
    always_comb begin
        win_idx = ~last_q;
        win_vld = 1'b0;
        if (state_q == ST_HOLD) begin
            win_idx = owner_q;
            win_vld = owner_q ? act1 : act0;
        end else if (act0 && act1) begin
            win_idx = ~last_q;
            win_vld = 1'b1;
        end else if (act0) begin
            win_idx = 1'b0;
            win_vld = 1'b1;
        end else if (act1) begin
            win_idx = 1'b1;
            win_vld = 1'b1;
        end
    end

    // Push is gated by the registered full flag, so a concurrent pop does
    // not free a slot until the following cycle.
    assign fire = rst_i & win_vld & mem_accept_i & ~fifo_full;
    assign push = fire;
    assign pop  = rst_i & mem_ack_i & ~fifo_empty;
    assign head = fifo_q[rd_ptr_q];

    assign mem_addr_o    = win_idx ? m1_addr_i    : m0_addr_i;
    assign mem_data_wr_o = win_idx ? m1_data_wr_i : m0_data_wr_i;
    assign mem_req_tag_o = win_idx ? m1_req_tag_i : m0_req_tag_i;
    assign sel_rd        = win_idx ? m1_rd_i      : m0_rd_i;
    assign sel_wr        = win_idx ? m1_wr_i      : m0_wr_i;

    assign mem_rd_o = sel_rd & win_vld & ~fifo_full & rst_i;
    assign mem_wr_o = (win_vld & ~fifo_full & rst_i) ? sel_wr : 4'h0;

    assign m0_accept_o = fire & ~win_idx;
    assign m1_accept_o = fire &  win_idx;

    // Only the ack is routed; error is qualified by the routed ack.
    assign m0_ack_o      = pop & ~head;
    assign m1_ack_o      = pop &  head;
    assign m0_error_o    = m0_ack_o & mem_error_i;
    assign m1_error_o    = m1_ack_o & mem_error_i;
    assign m0_resp_tag_o = mem_resp_tag_i;
    assign m1_resp_tag_o = mem_resp_tag_i;
    assign m0_data_rd_o  = mem_data_rd_i;
    assign m1_data_rd_o  = mem_data_rd_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (fire) begin
            last_d = win_idx;
        end
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !fire) begin
                    state_d = ST_HOLD;
                    owner_d = win_idx;
                end
            end
            default: begin
                if (fire) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= win_idx;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dport_arb.sv
module tb_dport_arb;

    localparam logic [10:0] T0 = 11'h001;
    localparam logic [10:0] T1 = 11'h101;
    localparam logic [10:0] TX = 11'h7FF;  // tag not checked

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_data_wr, m1_addr, m1_data_wr;
    logic        m0_rd, m1_rd;
    logic [3:0]  m0_wr, m1_wr;
    logic [10:0] m0_req_tag, m1_req_tag;
    logic        m0_accept, m0_ack, m0_error, m1_accept, m1_ack, m1_error;
    logic [10:0] m0_resp_tag, m1_resp_tag;
    logic [31:0] m0_data_rd, m1_data_rd;
    logic [31:0] mem_addr, mem_data_wr;
    logic        mem_rd;
    logic [3:0]  mem_wr;
    logic [10:0] mem_req_tag;
    logic        mem_accept, mem_ack, mem_error;
    logic [10:0] mem_resp_tag;
    logic [31:0] mem_data_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dport_arb #(.OUTSTANDING_DEPTH(4), .OUTSTANDING_W(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_wr_i(m0_data_wr), .m0_rd_i(m0_rd),
        .m0_wr_i(m0_wr), .m0_req_tag_i(m0_req_tag), .m0_accept_o(m0_accept),
        .m0_ack_o(m0_ack), .m0_error_o(m0_error), .m0_resp_tag_o(m0_resp_tag),
        .m0_data_rd_o(m0_data_rd),
        .m1_addr_i(m1_addr), .m1_data_wr_i(m1_data_wr), .m1_rd_i(m1_rd),
        .m1_wr_i(m1_wr), .m1_req_tag_i(m1_req_tag), .m1_accept_o(m1_accept),
        .m1_ack_o(m1_ack), .m1_error_o(m1_error), .m1_resp_tag_o(m1_resp_tag),
        .m1_data_rd_o(m1_data_rd),
        .mem_addr_o(mem_addr), .mem_data_wr_o(mem_data_wr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .mem_req_tag_o(mem_req_tag),
        .mem_accept_i(mem_accept), .mem_ack_i(mem_ack), .mem_error_i(mem_error),
        .mem_resp_tag_i(mem_resp_tag), .mem_data_rd_i(mem_data_rd)
    );

    typedef struct {
        logic        rst, r0;
        logic [3:0]  w0;
        logic        r1;
        logic [3:0]  w1;
        logic        acc, ack, err;
        logic        a0, a1, mrd;
        logic [3:0]  mwr;
        logic        k0, k1, e0, e1;
        logic [10:0] etag;
    } vec_t;

    vec_t vt[$];

    task automatic v(input logic rs, input logic r0, input logic [3:0] w0,
                     input logic r1, input logic [3:0] w1, input logic acc,
                     input logic ack, input logic err, input logic a0,
                     input logic a1, input logic mrd, input logic [3:0] mwr,
                     input logic k0, input logic k1, input logic e0,
                     input logic e1, input logic [10:0] etag);
        vec_t x;
        x.rst = rs; x.r0 = r0; x.w0 = w0; x.r1 = r1; x.w1 = w1;
        x.acc = acc; x.ack = ack; x.err = err;
        x.a0 = a0; x.a1 = a1; x.mrd = mrd; x.mwr = mwr;
        x.k0 = k0; x.k1 = k1; x.e0 = e0; x.e1 = e1; x.etag = etag;
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
        mem_accept = 0; mem_ack = 0; mem_error = 0;
        mem_resp_tag = '0; mem_data_rd = '0;
    endtask

    initial begin
        m0_addr = 32'h0000_1000; m0_data_wr = 32'h1111_1111; m0_req_tag = T0;
        m1_addr = 32'h8000_0010; m1_data_wr = 32'h2222_2222; m1_req_tag = T1;
        rst = 0;
        idle_in();

        // Reset: outputs forced low even with requests and ack present.
        v(0,1,0,1,0,1,1,0, 0,0,0,0,0,0,0,0,T0);
        // Continuous reads from both, ack one cycle after accept.
        v(1,1,0,1,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        v(1,1,0,1,0,1,1,0, 0,1,1,0,1,0,0,0,T1);
        v(1,1,0,1,0,1,1,0, 1,0,1,0,0,1,0,0,T0);
        v(1,1,0,1,0,1,1,0, 0,1,1,0,1,0,0,0,T1);
        v(1,0,0,0,0,1,1,0, 0,0,0,0,0,1,0,0,TX);
        // m1 write stalled 3 cycles, m0 joins in cycle 2: grant stays locked.
        v(1,0,0,0,4'hF,0,0,0, 0,0,0,4'hF,0,0,0,0,T1);
        v(1,1,0,0,4'hF,0,0,0, 0,0,0,4'hF,0,0,0,0,T1);
        v(1,1,0,0,4'hF,0,0,0, 0,0,0,4'hF,0,0,0,0,T1);
        v(1,1,0,0,4'hF,1,0,0, 0,1,0,4'hF,0,0,0,0,T1);
        v(1,1,0,0,0,1,1,0, 1,0,1,0,0,1,0,0,T0);
        v(1,0,0,0,0,1,1,0, 0,0,0,0,1,0,0,0,TX);
        // Error response with head = m1.
        v(1,0,0,1,0,1,0,0, 0,1,1,0,0,0,0,0,T1);
        v(1,0,0,0,0,1,1,1, 0,0,0,0,0,1,0,1,TX);
        // Fill the FIFO with 4 m0 reads; 5th is blocked, even during the pop.
        for (int i = 0; i < 4; i++) v(1,1,0,0,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        v(1,1,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,T0);
        v(1,1,0,0,0,1,1,0, 0,0,0,0,1,0,0,0,T0);
        v(1,1,0,0,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        for (int i = 0; i < 4; i++) v(1,0,0,0,0,0,1,0, 0,0,0,0,1,0,0,0,TX);
        // Stray ack with empty FIFO is dropped.
        v(1,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,0,TX);
        // Count 2, then 10 cycles of simultaneous push and pop.
        v(1,1,0,1,0,1,0,0, 0,1,1,0,0,0,0,0,T1);
        v(1,1,0,1,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        for (int i = 0; i < 10; i++) begin
            logic o;
            o = logic'(i % 2);
            v(1,1,0,1,0,1,1,0, o,~o,1,0,o,~o,0,0, o ? T0 : T1);
        end
        v(1,0,0,0,0,0,1,0, 0,0,0,0,0,1,0,0,TX);
        v(1,0,0,0,0,0,1,0, 0,0,0,0,1,0,0,0,TX);
        // Three outstanding, reset, stray acks, then first tie goes to m0.
        v(1,1,0,0,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        v(1,0,0,1,0,1,0,0, 0,1,1,0,0,0,0,0,T1);
        v(1,1,0,0,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        v(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,0,TX);
        for (int i = 0; i < 3; i++) v(1,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,0,TX);
        v(1,1,0,1,0,1,0,0, 1,0,1,0,0,0,0,0,T0);
        v(1,0,0,0,0,0,1,0, 0,0,0,0,1,0,0,0,TX);

        repeat (2) @(posedge clk);

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst;
            m0_rd = vt[i].r0; m0_wr = vt[i].w0;
            m1_rd = vt[i].r1; m1_wr = vt[i].w1;
            mem_accept = vt[i].acc; mem_ack = vt[i].ack; mem_error = vt[i].err;
            #1;
            chk($sformatf("v%0d m0_accept", i), 32'(m0_accept), 32'(vt[i].a0));
            chk($sformatf("v%0d m1_accept", i), 32'(m1_accept), 32'(vt[i].a1));
            chk($sformatf("v%0d mem_rd", i),    32'(mem_rd),    32'(vt[i].mrd));
            chk($sformatf("v%0d mem_wr", i),    32'(mem_wr),    32'(vt[i].mwr));
            chk($sformatf("v%0d m0_ack", i),    32'(m0_ack),    32'(vt[i].k0));
            chk($sformatf("v%0d m1_ack", i),    32'(m1_ack),    32'(vt[i].k1));
            chk($sformatf("v%0d m0_error", i),  32'(m0_error),  32'(vt[i].e0));
            chk($sformatf("v%0d m1_error", i),  32'(m1_error),  32'(vt[i].e1));
            if (vt[i].etag != TX)
                chk($sformatf("v%0d mem_req_tag", i), 32'(mem_req_tag), 32'(vt[i].etag));
        end

        // Hand sequence: address/data follow the locked owner, response
        // payload passes through to both requesters.
        @(negedge clk);
        idle_in();
        m1_wr = 4'hF;
        #1;
        chk("h1 mem_addr", mem_addr, 32'h8000_0010);
        chk("h1 mem_data_wr", mem_data_wr, 32'h2222_2222);
        chk("h1 m1_accept", 32'(m1_accept), 32'd0);
        @(negedge clk);
        m0_rd = 1;
        #1;
        chk("h2 mem_addr", mem_addr, 32'h8000_0010);
        chk("h2 mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        #1;
        chk("h3 mem_addr", mem_addr, 32'h8000_0010);
        @(negedge clk);
        mem_accept = 1;
        #1;
        chk("h4 m1_accept", 32'(m1_accept), 32'd1);
        chk("h4 m0_accept", 32'(m0_accept), 32'd0);
        @(negedge clk);
        m1_wr = 0;
        #1;
        chk("h5 m0_accept", 32'(m0_accept), 32'd1);
        chk("h5 mem_addr", mem_addr, 32'h0000_1000);
        @(negedge clk);
        idle_in();
        mem_ack = 1; mem_resp_tag = 11'h5A5; mem_data_rd = 32'hDEAD_BEEF;
        #1;
        chk("h6 m1_ack", 32'(m1_ack), 32'd1);
        chk("h6 m0_ack", 32'(m0_ack), 32'd0);
        chk("h6 m0_resp_tag", 32'(m0_resp_tag), 32'h5A5);
        chk("h6 m1_resp_tag", 32'(m1_resp_tag), 32'h5A5);
        chk("h6 m0_data_rd", m0_data_rd, 32'hDEAD_BEEF);
        chk("h6 m1_data_rd", m1_data_rd, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("h7 m0_ack", 32'(m0_ack), 32'd1);
        @(negedge clk);
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
